// File: rtl/operand_entry_adder.sv
// Two-operand entry front end for the signed-sum display.
// Each debounced button press captures the switch value as operand A, then operand B,
// then shows the result. The 4-bit sum and the signed overflow flag are computed and
// registered on the operand B capture.
module operand_entry_adder #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 19
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sw,
  input  logic       key_n,
  output logic [3:0] input1,
  output logic [3:0] input2,
  output logic [3:0] sum,
  output logic       overflow,
  output logic [1:0] entry_state,
  output logic       sum_valid
);

  typedef enum logic [1:0] {
    StLoadA = 2'b00,
    StLoadB = 2'b01,
    StShow  = 2'b10
  } state_e;

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             db_q, db_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_ev;

  state_e           state_q, state_d;
  logic [3:0]       in1_q, in1_d;
  logic [3:0]       in2_q, in2_d;
  logic [3:0]       sum_q, sum_d;
  logic             ovf_q, ovf_d;
  logic [3:0]       sum_next;

  // Two-flop synchronizer; idles at the released level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: accept a new level only after it has differed for DEBOUNCE_CYCLES cycles.
  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    if (sync2_q != db_q) begin
      if (cnt_q == CntMax) begin
        db_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      db_q  <= 1'b1;
      cnt_q <= '0;
    end else begin
      db_q  <= db_d;
      cnt_q <= cnt_d;
    end
  end

  // Press is the accepted 1->0 transition; the FSM acts on the same edge that updates db_q.
  assign press_ev = db_q & ~db_d;

  assign sum_next = in1_q + sw;

  // Entry FSM next-state and data capture.
  always_comb begin
    state_d = state_q;
    in1_d   = in1_q;
    in2_d   = in2_q;
    sum_d   = sum_q;
    ovf_d   = ovf_q;
    case (state_q)
      StLoadA: begin
        if (press_ev) begin
          in1_d   = sw;
          state_d = StLoadB;
        end
      end
      StLoadB: begin
        if (press_ev) begin
          in2_d   = sw;
          sum_d   = sum_next;
          ovf_d   = (in1_q[3] == sw[3]) && (sum_next[3] != in1_q[3]);
          state_d = StShow;
        end
      end
      StShow: begin
        if (press_ev) begin
          state_d = StLoadA;
        end
      end
      // Unused encoding recovers to LOAD_A.
      default: state_d = StLoadA;
    endcase
  end

  // FSM and data registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StLoadA;
      in1_q   <= '0;
      in2_q   <= '0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      in1_q   <= in1_d;
      in2_q   <= in2_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
    end
  end

  assign input1      = in1_q;
  assign input2      = in2_q;
  assign sum         = sum_q;
  assign overflow    = ovf_q;
  assign entry_state = state_q;
  assign sum_valid   = (state_q == StShow);

endmodule

// File: doc/operand_entry_adder.md
Name: operand_entry_adder

Overview:
- Upstream feeder for the signed-sum HEX display stage.
- Captures two 4-bit two's-complement operands from slide switches, one per debounced push-button press.
- Computes their registered 4-bit sum and signed overflow flag.
- Presents `input1`, `input2`, `sum` and `overflow` as stable registered values that drive the display stage directly.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable clk cycles required before a button level change is accepted (10 ms at 50 MHz); benches override to a small value.
- CNT_W, 19, width of the debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- sw  input  4  operand source switches, two's complement
- key_n  input  1  push button, active low, asynchronous to clk, bouncy
- input1  output  4  captured operand A
- input2  output  4  captured operand B
- sum  output  4  registered input1+input2, modulo 16
- overflow  output  1  signed overflow of the captured sum
- entry_state  output  2  FSM state: 00 LOAD_A, 01 LOAD_B, 10 SHOW
- sum_valid  output  1  high while in SHOW

Behaviour:
- Reset (rst high at a clk edge) forces all of the following:
  - input1=0, input2=0, sum=0, overflow=0, sum_valid=0.
  - entry_state=LOAD_A.
  - Synchronizer flops=1, debounced level=1 (released), debounce counter=0.
  - Reset wins over any simultaneous press event.
- Synchronizer:
  - key_n passes through two flops.
  - Only the second flop output (ks) is used downstream.
- Debounce:
  - If ks equals the debounced level, the counter clears to 0.
  - Otherwise the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 while ks still differs, the debounced level takes ks and the counter clears.
  - Any return of ks to the debounced level before that point clears the counter, so the glitch is discarded.
- Press event:
  - A 1-cycle pulse on the cycle the debounced level changes 1->0.
  - A release (0->1) produces no event.
  - A held button produces exactly one event.
- Press latency: at most 2 (sync) + DEBOUNCE_CYCLES cycles from a stable key_n fall to the event pulse.
- FSM transitions, each taken on the clk edge that samples the event pulse:
  - LOAD_A + event: input1 <= sw; go to LOAD_B.
  - LOAD_B + event: the following happen in the same edge, then go to SHOW.
    - input2 <= sw.
    - sum <= (input1 + sw)[3:0].
    - overflow <= (input1[3]==sw[3]) && (sum_next[3]!=input1[3]).
  - SHOW + event: go to LOAD_A. input1, input2, sum and overflow hold their values until overwritten.
  - No event: state and all data registers hold.
  - Encoding 11 is unreachable; if entered, the next edge goes to LOAD_A.
- Timing:
  - sum and overflow are valid on the cycle after the LOAD_B event edge, together with sum_valid=1.
  - There is no combinational path from sw to any output.
- sw changes outside an event cycle have no effect.
- The LOAD_A capture does not alter sum or overflow; the display keeps the previous result until the new LOAD_B capture.
- Button held low across reset deassertion:
  - The debounced level restarts at 1.
  - One event fires DEBOUNCE_CYCLES+2 cycles after reset deasserts.
- Reset mid-debounce or mid-entry: the counter and FSM restart cleanly, with no pending event retained.
- Overflow examples (operand, operand -> sum, overflow):
  - 7, 1 -> 1000, overflow 1.
  - -8, -1 -> 0111, overflow 1.
  - -8, 7 -> 1111, overflow 0.

Test Plan:
- All scenarios run with DEBOUNCE_CYCLES=4.
- Reset: assert rst 2 cycles with key_n=1 -> all outputs 0, entry_state=00, sum_valid=0.
- Press sequence sw=0011, then sw=0100, each key_n held low 10 cycles with releases between:
  - After the first press: input1=0011, entry_state=01.
  - After the second press: input2=0100, sum=0111, overflow=0, sum_valid=1, entry_state=10.
- Overflow entries:
  - 0111 then 0001 -> sum=1000, overflow=1.
  - A third press returns entry_state=00 with input1, input2, sum and overflow unchanged.
  - Then 1000 then 1111 -> sum=0111, overflow=1.
- Negative non-overflow: 1101 then 0010 -> sum=1111, overflow=0.
- Bounce:
  - key_n low 2 cycles then high -> no state change.
  - key_n toggling every cycle for 20 cycles then held low 10 cycles -> exactly one capture.
  - A 30-cycle hold -> one capture; the release generates none.
- Reset mid-entry:
  - In LOAD_B, pulse rst for 1 cycle on the same edge as a press event -> entry_state=00, all data outputs 0.
  - A subsequent full entry still works.
